// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU arbiter and its ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] OP_AND = 4'b0000;
  localparam logic [SEL_W-1:0] OP_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] OP_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // One captured operation: who asked, what to do, and the operands.
  typedef struct packed {
    logic              id;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  // Response register contents presented on the Rsp_* ports.
  typedef struct packed {
    logic              id;
    logic              err;
    logic              zero;
    logic [DATA_W-1:0] out;
  } rsp_t;

endpackage

// File: rtl/alu.sv
// 8-bit ALU (AND/OR/ADD/SUB) with a registered result and zero flag.
// Latency: ALU_LAT clock edges from operand change to out/zero.
// Backpressure: none; free-running pipeline, caller decides when to sample.
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out,
  output logic              zero
);

  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   pipe [ALU_LAT];

  // Combinational function select; unknown opcodes give 0 and are flagged upstream.
  always_comb begin
    res = '0;
    case (sel)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      default: res = '0;
    endcase
  end

  // Delay line carrying {zero, result} through ALU_LAT register stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {(res == '0), res};
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out  = pipe[ALU_LAT-1][DATA_W-1:0];
  assign zero = pipe[ALU_LAT-1][DATA_W];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one shared ALU, single operation in flight.
// Latency: Rsp_valid rises ALU_LAT+1 edges after the accept edge.
// Backpressure: Rsp_* held until Rsp_ready; no new accept until the handshake.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0_valid,
  output logic              Req0_ready,
  input  logic [DATA_W-1:0] Req0_A,
  input  logic [DATA_W-1:0] Req0_B,
  input  logic [SEL_W-1:0]  Req0_Sel,
  input  logic              Req1_valid,
  output logic              Req1_ready,
  input  logic [DATA_W-1:0] Req1_A,
  input  logic [DATA_W-1:0] Req1_B,
  input  logic [SEL_W-1:0]  Req1_Sel,
  output logic              Rsp_valid,
  input  logic              Rsp_ready,
  output logic              Rsp_id,
  output logic [DATA_W-1:0] Rsp_out,
  output logic              Rsp_zero,
  output logic              Rsp_err,
  output logic              Busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 1) + 1;

  state_t            state_q, state_d;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  op_t               op_q;
  rsp_t              rsp_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic              accept;
  logic              capture;
  logic              sel_ok;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;

  // Round-robin pick: on a tie favour the requester not granted last.
  always_comb begin
    gnt_vld = Req0_valid | Req1_valid;
    gnt_id  = 1'b0;
    if (Req0_valid && Req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = Req1_valid;
    end
  end

  // Opcode validity lives here so the ALU stays a pure datapath.
  always_comb begin
    sel_ok = 1'b0;
    case (op_q.sel)
      OP_AND, OP_OR, OP_ADD, OP_SUB: sel_ok = 1'b1;
      default:                       sel_ok = 1'b0;
    endcase
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (Rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted operation and remember who won.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q   <= '0;
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt_id;
      if (gnt_id) begin
        op_q <= '{id: 1'b1, sel: Req1_Sel, a: Req1_A, b: Req1_B};
      end else begin
        op_q <= '{id: 1'b0, sel: Req0_Sel, a: Req0_A, b: Req0_B};
      end
    end
  end

  // WAIT counter: lets the ALU pipeline settle on the captured operands.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (accept || capture) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response registers; an invalid opcode overrides the ALU result.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_q <= '0;
    end else if (capture) begin
      rsp_q.id   <= op_q.id;
      rsp_q.err  <= ~sel_ok;
      rsp_q.zero <= sel_ok & alu_zero;
      rsp_q.out  <= sel_ok ? alu_out : '0;
    end
  end

  alu #(
    .ALU_LAT (ALU_LAT)
  ) u_alu (
    .clk   (Clk),
    .rst_n (Rst_n),
    .a     (op_q.a),
    .b     (op_q.b),
    .sel   (op_q.sel),
    .out   (alu_out),
    .zero  (alu_zero)
  );

  // Readies are forced low while reset is held, even though state reads IDLE.
  assign Req0_ready = Rst_n & accept & ~gnt_id;
  assign Req1_ready = Rst_n & accept &  gnt_id;

  assign Rsp_valid = (state_q == RESP);
  assign Busy      = (state_q != IDLE);
  assign Rsp_id    = rsp_q.id;
  assign Rsp_out   = rsp_q.out;
  assign Rsp_zero  = rsp_q.zero;
  assign Rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  typedef struct packed {
    logic       id;
    logic       err;
    logic       zero;
    logic [7:0] out;
  } exp_t;

  logic       Clk;
  logic       Rst_n;
  logic       Req0_valid, Req1_valid;
  logic       Req0_ready, Req1_ready;
  logic [7:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic [3:0] Req0_Sel, Req1_Sel;
  logic       Rsp_valid, Rsp_ready;
  logic       Rsp_id;
  logic [7:0] Rsp_out;
  logic       Rsp_zero, Rsp_err, Busy;

  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  alu_arbiter #(.ALU_LAT(1)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req0_valid (Req0_valid),
    .Req0_ready (Req0_ready),
    .Req0_A     (Req0_A),
    .Req0_B     (Req0_B),
    .Req0_Sel   (Req0_Sel),
    .Req1_valid (Req1_valid),
    .Req1_ready (Req1_ready),
    .Req1_A     (Req1_A),
    .Req1_B     (Req1_B),
    .Req1_Sel   (Req1_Sel),
    .Rsp_valid  (Rsp_valid),
    .Rsp_ready  (Rsp_ready),
    .Rsp_id     (Rsp_id),
    .Rsp_out    (Rsp_out),
    .Rsp_zero   (Rsp_zero),
    .Rsp_err    (Rsp_err),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] sel);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    e.out = 8'h00;
    case (sel)
      4'b0000: e.out = a & b;
      4'b0001: e.out = a | b;
      4'b0010: e.out = 8'((a + b) & 9'h0FF);
      4'b0110: e.out = 8'((9'h100 + a - b) & 9'h0FF);
      default: begin e.out = 8'h00; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.out == 8'h00);
    return e;
  endfunction

  // Scoreboard: every completed handshake pops the oldest expected response.
  always @(negedge Clk) begin : mon
    exp_t got;
    exp_t want;
    if (Rst_n === 1'b1 && Rsp_valid === 1'b1 && Rsp_ready === 1'b1) begin
      rsp_count++;
      checks++;
      got = '{Rsp_id, Rsp_err, Rsp_zero, Rsp_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got id=%0d out=%h zero=%0d err=%0d, none expected",
                 got.id, got.out, got.zero, got.err);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL rsp_data got id=%0d out=%h zero=%0d err=%0d want id=%0d out=%h zero=%0d err=%0d",
                   got.id, got.out, got.zero, got.err, want.id, want.out, want.zero, want.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Present one request, push its expectation on accept; returns at accept edge + 1.
  task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] sel, output bit ok);
    if (id) begin
      Req1_A = a; Req1_B = b; Req1_Sel = sel; Req1_valid = 1'b1;
    end else begin
      Req0_A = a; Req0_B = b; Req0_Sel = sel; Req0_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clk);
      if ((id ? Req1_ready : Req0_ready) === 1'b1) begin
        exp_q.push_back(model(id, a, b, sel));
        ok = 1'b1;
      end
    end
    @(posedge Clk); #1;
    Req0_valid = 1'b0;
    Req1_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge Clk); #1;
      if (exp_q.size() == 0 && Rsp_valid === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    Rsp_ready = 1'b0;
    Req0_valid = 1'b1; Req1_valid = 1'b1;
    Req0_A = 8'h00; Req0_B = 8'h00; Req0_Sel = 4'h0;
    Req1_A = 8'h00; Req1_B = 8'h00; Req1_Sel = 4'h0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Rsp_valid, Busy, Req0_ready, Req1_ready, Rsp_zero, Rsp_err, Rsp_id} !== 7'b0 ||
        Rsp_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got vld=%b busy=%b r0=%b r1=%b z=%b e=%b id=%b out=%h want all 0",
               Rsp_valid, Busy, Req0_ready, Req1_ready, Rsp_zero, Rsp_err, Rsp_id, Rsp_out);
    end
    Req0_valid = 1'b0; Req1_valid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  // Send one op alone and check latency plus fixed expected fields.
  task automatic one_op(input string name, input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sel, input logic [7:0] x_out, input logic x_zero,
                        input logic x_err);
    bit ok;
    int lat;
    Rsp_ready = 1'b1;
    send(id, a, b, sel, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_accept got no ready want ready", name); end
    lat = 0;
    while (Rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL %s_latency got=%0d want=2", name, lat); end
    checks++;
    if (Rsp_out !== x_out || Rsp_zero !== x_zero || Rsp_err !== x_err || Rsp_id !== id) begin
      errors++;
      $display("FAIL %s_fields got out=%h z=%b e=%b id=%b want out=%h z=%b e=%b id=%b",
               name, Rsp_out, Rsp_zero, Rsp_err, Rsp_id, x_out, x_zero, x_err, id);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_drain got pending=%0d want 0", name, exp_q.size()); end
  endtask

  task automatic test_add;
    one_op("add", 1'b0, 8'h55, 8'hAA, 4'b0010, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_invalid_op;
    one_op("badop", 1'b0, 8'hAA, 8'h55, 4'b1111, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_sub;
    one_op("sub", 1'b1, 8'hFF, 8'hFF, 4'b0110, 8'h00, 1'b1, 1'b0);
  endtask

  // Both requesters valid continuously; grants must alternate 0,1,0 every 4 cycles.
  task automatic test_back_to_back;
    bit ok;
    bit exp_id [3];
    int n, last_acc, t;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
    Rsp_ready = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'h88});
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'hEE});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'h88});
    Req0_A = 8'hCC; Req0_B = 8'hAA; Req0_Sel = 4'b0000;
    Req1_A = 8'hCC; Req1_B = 8'hAA; Req1_Sel = 4'b0001;
    Req0_valid = 1'b1; Req1_valid = 1'b1;
    n = 0; last_acc = 0; t = 0;
    while (n < 3 && t < 60) begin
      @(negedge Clk);
      t++;
      if (Req0_ready === 1'b1 || Req1_ready === 1'b1) begin
        checks++;
        if ({Req1_ready, Req0_ready} !== (exp_id[n] ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant%0d got r1r0=%b%b want id %0d", n, Req1_ready, Req0_ready, exp_id[n]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_acc != 4) begin
            errors++;
            $display("FAIL rr_interval%0d got=%0d want=4", n, cyc - last_acc);
          end
        end
        last_acc = cyc;
        n++;
      end
    end
    @(posedge Clk); #1;
    Req0_valid = 1'b0; Req1_valid = 1'b0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL rr_count got=%0d want=3", n); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain got pending=%0d want 0", exp_q.size()); end
  endtask

  // Consumer stalls 5 cycles: response and handshake signals must hold.
  task automatic test_backpressure;
    bit ok;
    int t, bad, cnt0;
    Rsp_ready = 1'b0;
    send(1'b0, 8'h10, 8'h20, 4'b0010, ok);
    t = 0;
    while (Rsp_valid !== 1'b1 && t < 10) begin @(posedge Clk); #1; t++; end
    checks++;
    if (Rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b want=1", Rsp_valid); end
    Req0_valid = 1'b1; Req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Rsp_valid !== 1'b1 || Rsp_out !== 8'h30 || Rsp_id !== 1'b0 || Rsp_zero !== 1'b0 ||
          Rsp_err !== 1'b0 || Busy !== 1'b1 || Req0_ready !== 1'b0 || Req1_ready !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles (out=%h busy=%b r0=%b r1=%b) want 0",
               bad, Rsp_out, Busy, Req0_ready, Req1_ready);
    end
    @(posedge Clk); #1;
    Req0_valid = 1'b0; Req1_valid = 1'b0;
    cnt0 = rsp_count;
    Rsp_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (rsp_count - cnt0 != 1 || Rsp_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_release got rsps=%0d vld=%b pending=%0d want 1,0,0",
               rsp_count - cnt0, Rsp_valid, exp_q.size());
    end
  endtask

  // Reset in WAIT drops the op, clears outputs, and restores the Req0 tie preference.
  task automatic test_reset_in_flight;
    bit ok;
    int seen;
    Rsp_ready = 1'b1;
    send(1'b0, 8'h0F, 8'hF0, 4'b0000, ok);
    checks++;
    if (Busy !== 1'b1 || Rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre got busy=%b vld=%b want busy=1 vld=0", Busy, Rsp_valid);
    end
    #2;
    Req0_valid = 1'b1; Req1_valid = 1'b1;
    Rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({Rsp_valid, Busy, Req0_ready, Req1_ready, Rsp_zero, Rsp_err, Rsp_id} !== 7'b0 ||
        Rsp_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_async got vld=%b busy=%b r0=%b r1=%b z=%b e=%b id=%b out=%h want all 0",
               Rsp_valid, Busy, Req0_ready, Req1_ready, Rsp_zero, Rsp_err, Rsp_id, Rsp_out);
    end
    Req0_valid = 1'b0; Req1_valid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (Rsp_valid !== 1'b0 || Busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_no_rsp got %0d active cycles want 0", seen); end
    Req0_A = 8'hCC; Req0_B = 8'hAA; Req0_Sel = 4'b0000;
    Req1_A = 8'hCC; Req1_B = 8'hAA; Req1_Sel = 4'b0001;
    Req0_valid = 1'b1; Req1_valid = 1'b1;
    @(negedge Clk);
    checks++;
    if (Req0_ready !== 1'b1 || Req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie got r0=%b r1=%b want r0=1 r1=0", Req0_ready, Req1_ready);
    end
    if (Req0_ready === 1'b1) exp_q.push_back(model(1'b0, 8'hCC, 8'hAA, 4'b0000));
    if (Req1_ready === 1'b1) exp_q.push_back(model(1'b1, 8'hCC, 8'hAA, 4'b0001));
    @(posedge Clk); #1;
    Req0_valid = 1'b0; Req1_valid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_drain got pending=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_invalid_op();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_in_flight();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got pending=%0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
